// File: rtl/spdif_pkg.sv
// spdif_pkg
// Shared constants and types for the S/PDIF (IEC 60958) transmitter:
// frame geometry, the three preamble cell patterns, and the 192-bit
// consumer channel-status vector. The vector is only consumed when
// SPDIF_TX_CHSTAT_EN is defined.
package spdif_pkg;

  localparam int CELLS_PER_FRAME  = 128;
  localparam int FRAMES_PER_BLOCK = 192;
  localparam int PREAMBLE_SLOTS   = 4;

  // Preamble cell patterns, first transmitted cell in the MSB. These are
  // the forms used when the line sits at 0 before the preamble.
  localparam logic [7:0] PREAMBLE_B = 8'b11101000;
  localparam logic [7:0] PREAMBLE_M = 8'b11100010;
  localparam logic [7:0] PREAMBLE_W = 8'b11100100;

  typedef enum logic [1:0] {
    PRE_B = 2'd0,
    PRE_M = 2'd1,
    PRE_W = 2'd2
  } preamble_e;

  // Consumer channel status, bit index = frame number within the block:
  // bit 0 = 0 consumer, bit 1 = 0 linear PCM, bit 2 = 1 copy permitted,
  // bits 24..27 = 0100 (48 kHz), bits 32..35 = 0100 (16-bit word).
  localparam logic [191:0] CHSTAT_VECTOR = (192'd1 << 2)
                                         | (192'd1 << 25)
                                         | (192'd1 << 33);

  function automatic logic [7:0] preamble_pattern(input preamble_e kind);
    logic [7:0] pat;
    case (kind)
      PRE_B:   pat = PREAMBLE_B;
      PRE_M:   pat = PREAMBLE_M;
      PRE_W:   pat = PREAMBLE_W;
      default: pat = PREAMBLE_M;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/spdif_bmc.sv
// spdif_bmc
// Combinational biphase-mark cell encoder. Produces the line level of the
// current half-cell from the level of the previous half-cell.
// Ports:
//   bit_i       slot data bit (ignored during preamble)
//   half_i      0 = first half of the slot, 1 = second half
//   preamble_i  1 while the current cell belongs to a preamble
//   pre_bit_i   preamble pattern bit for this cell
//   pre_inv_i   1 when the whole preamble must be sent inverted
//   prev_i      line level of the previous half-cell
//   level_o     line level for this half-cell
module spdif_bmc
  import spdif_pkg::*;
(
  input  logic bit_i,
  input  logic half_i,
  input  logic preamble_i,
  input  logic pre_bit_i,
  input  logic pre_inv_i,
  input  logic prev_i,
  output logic level_o
);

  // Preambles are literal patterns (they deliberately break the biphase
  // rule so a receiver can find them). Data slots always toggle at slot
  // start and toggle again mid-slot only for a 1.
  always_comb begin
    level_o = ~prev_i;
    if (preamble_i) begin
      level_o = pre_bit_i ^ pre_inv_i;
    end else if (half_i) begin
      level_o = bit_i ? ~prev_i : prev_i;
    end
  end

endmodule

// File: rtl/spdif_tx.sv
// spdif_tx
// S/PDIF (IEC 60958) transmitter for 16-bit stereo. One clock = one
// biphase half-cell; 128 cells per frame, 192 frames per block.
// Optional feature: define SPDIF_TX_CHSTAT_EN to send the consumer
// channel-status vector in slot 30; otherwise C is always 0.
// Ports:
//   clk          128*Fs cell clock
//   reset        synchronous, active-high
//   data_in      stereo word, [31:16] channel A, [15:0] channel B
//   data_stb_in  one-cycle strobe, data_in valid
//   done         pulse: held sample moved into the frame register
//   spdif_out    registered biphase-mark line
//   underrun     pulse: frame started without a new sample
//   block_start  high during the first cycle of frame 0
// The line register shows cell k of a frame in the cycle after the
// counters point at cell k; the level of the previous cell is therefore
// always the current line register value.
module spdif_tx
  import spdif_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_stb_in,
  output logic                  done,
  output logic                  spdif_out,
  output logic                  underrun,
  output logic                  block_start
);

  logic [6:0]            cell_cnt_q, cell_cnt_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic                  vflag_q, vflag_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  pre_inv_q, pre_inv_d;
  logic                  spdif_q;

  logic                  sub_b;
  logic [4:0]            slot;
  logic                  half;
  logic [2:0]            pre_idx;
  logic                  in_preamble;
  preamble_e             pre_kind;
  logic [7:0]            pre_bits;
  logic                  pre_bit;
  logic                  pre_inv;
  logic [15:0]           sample;
  logic [3:0]            bit_idx;
  logic                  c_bit;
  logic                  parity;
  logic                  slot_bit;
  logic                  frame_end;
  logic                  level;

  // Position within the frame: bit 6 picks the subframe, bits 5:1 the
  // slot, bit 0 the half-cell.
  always_comb begin
    sub_b       = cell_cnt_q[6];
    slot        = cell_cnt_q[5:1];
    half        = cell_cnt_q[0];
    pre_idx     = cell_cnt_q[2:0];
    in_preamble = (slot < 5'(PREAMBLE_SLOTS));
    pre_kind    = PRE_M;
    if (sub_b) begin
      pre_kind = PRE_W;
    end else if (frame_cnt_q == 8'd0) begin
      pre_kind = PRE_B;
    end
    pre_bits = preamble_pattern(pre_kind);
    pre_bit  = pre_bits[3'd7 - pre_idx];
    sample   = sub_b ? frame_q[15:0] : frame_q[DATA_WIDTH-1 -: 16];
  end

  // The inversion decision is taken from the line level just before the
  // first preamble cell and held for the remaining seven cells.
  always_comb begin
    pre_inv   = (pre_idx == 3'd0) ? spdif_q : pre_inv_q;
    pre_inv_d = in_preamble ? pre_inv : pre_inv_q;
  end

`ifdef SPDIF_TX_CHSTAT_EN
  assign c_bit = CHSTAT_VECTOR[frame_cnt_q];
`else
  assign c_bit = 1'b0;
`endif

  // Slots 4..11 carry the unused LSBs of a 24-bit word, so the 16-bit
  // sample starts at slot 12. Parity makes slots 4..31 even.
  always_comb begin
    parity   = (^sample) ^ vflag_q ^ c_bit;
    bit_idx  = slot[3:0] - 4'd12;
    slot_bit = 1'b0;
    if (slot >= 5'd12 && slot <= 5'd27) begin
      slot_bit = sample[bit_idx];
    end else if (slot == 5'd28) begin
      slot_bit = vflag_q;
    end else if (slot == 5'd30) begin
      slot_bit = c_bit;
    end else if (slot == 5'd31) begin
      slot_bit = parity;
    end
  end

  spdif_bmc u_bmc (
    .bit_i      (slot_bit),
    .half_i     (half),
    .preamble_i (in_preamble),
    .pre_bit_i  (pre_bit),
    .pre_inv_i  (pre_inv),
    .prev_i     (spdif_q),
    .level_o    (level)
  );

  // Counters, holding register and frame hand-over. A strobe that lands
  // on the hand-over cycle survives in the holding register because the
  // transfer reads the old hold_q.
  always_comb begin
    frame_end    = (cell_cnt_q == 7'(CELLS_PER_FRAME - 1));
    cell_cnt_d   = cell_cnt_q + 7'd1;
    frame_cnt_d  = frame_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    frame_d      = frame_q;
    vflag_d      = vflag_q;
    done_d       = 1'b0;
    underrun_d   = 1'b0;
    if (frame_end) begin
      frame_cnt_d  = (frame_cnt_q == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0
                                                                : frame_cnt_q + 8'd1;
      hold_valid_d = 1'b0;
      if (hold_valid_q) begin
        frame_d = hold_q;
        vflag_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        vflag_d    = 1'b1;
        underrun_d = 1'b1;
      end
    end
    if (data_stb_in) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end
  end

  // After reset the frame register is empty, so the first frame is sent
  // as an invalid (V=1) silent frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cell_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      frame_q      <= '0;
      vflag_q      <= 1'b1;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      pre_inv_q    <= 1'b0;
      spdif_q      <= 1'b0;
    end else begin
      cell_cnt_q   <= cell_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      frame_q      <= frame_d;
      vflag_q      <= vflag_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      pre_inv_q    <= pre_inv_d;
      spdif_q      <= level;
    end
  end

  assign done        = done_q;
  assign underrun    = underrun_q;
  assign spdif_out   = spdif_q;
  assign block_start = (cell_cnt_q == 7'd0) && (frame_cnt_q == 8'd0);

endmodule

// File: tb/tb_spdif_tx.sv
// tb_spdif_tx
// Directed bench for spdif_tx. Each frame is captured cell by cell from
// the line, decoded as a receiver would (preamble, biphase bits, V/U/C/P)
// and compared against hand-computed values.
module tb_spdif_tx;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        data_stb_in;
  logic        done;
  logic        spdif_out;
  logic        underrun;
  logic        block_start;

  int compared;
  int mismatched;
  int cycleCnt;

  logic [127:0] lineCells;
  logic         startLevel;
  logic         bsAtStart;
  int           bsOther;
  int           doneCnt;
  int           doneAt;
  int           underCnt;
  int           underAt;

  logic [7:0]   preA, preB;
  logic [15:0]  smpA, smpB;
  logic         vA, vB, uA, uB, cA, cB, parA, parB;
  int           bmcErr;

  logic [191:0] benchCs;

  spdif_tx #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_stb_in (data_stb_in),
    .done        (done),
    .spdif_out   (spdif_out),
    .underrun    (underrun),
    .block_start (block_start)
  );

  // 6.144 MHz is not needed for function; any period works.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison with an immediate assertion.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Run one frame starting at the negedge of its cell-0 cycle, optionally
  // strobing data at two cell positions, and capture all 128 line cells.
  // Cell k appears on the line one cycle after the counter points at it.
  task automatic applyStimulus(input int c1, input logic [31:0] d1,
                               input int c2, input logic [31:0] d2);
    startLevel = spdif_out;
    bsAtStart  = block_start;
    bsOther    = 0;
    doneCnt    = 0;
    doneAt     = -1;
    underCnt   = 0;
    underAt    = -1;
    for (int k = 0; k < 128; k++) begin
      data_stb_in = 1'b0;
      if (k == c1) begin
        data_stb_in = 1'b1;
        data_in     = d1;
      end
      if (k == c2) begin
        data_stb_in = 1'b1;
        data_in     = d2;
      end
      @(negedge clk);
      cycleCnt++;
      lineCells[k] = spdif_out;
      if (done === 1'b1) begin
        doneCnt++;
        doneAt = k;
      end
      if (underrun === 1'b1) begin
        underCnt++;
        underAt = k;
      end
      if (k < 127 && block_start !== 1'b0) bsOther++;
    end
    data_stb_in = 1'b0;
  endtask

  // Receiver-style decode of the captured frame.
  task automatic decodeFrame();
    logic [31:0] sb;
    logic [7:0]  pat;
    logic        prev;
    int          base;
    bmcErr = 0;
    for (int sf = 0; sf < 2; sf++) begin
      base = 64 * sf;
      prev = (sf == 0) ? startLevel : lineCells[63];
      for (int p = 0; p < 8; p++) pat[7-p] = lineCells[base+p] ^ prev;
      sb = '0;
      for (int s = 4; s < 32; s++) begin
        if (lineCells[base+2*s] === lineCells[base+2*s-1]) bmcErr++;
        sb[s] = lineCells[base+2*s] ^ lineCells[base+2*s+1];
      end
      if (sf == 0) begin
        preA = pat; smpA = sb[27:12]; vA = sb[28]; uA = sb[29]; cA = sb[30];
        parA = ^sb[31:4];
      end else begin
        preB = pat; smpB = sb[27:12]; vB = sb[28]; uB = sb[29]; cB = sb[30];
        parB = ^sb[31:4];
      end
    end
  endtask

  initial begin
    logic [31:0] expData;
    logic        expV;
    logic [31:0] feed;
    int          fr;
    int          dn;

    compared    = 0;
    mismatched  = 0;
    cycleCnt    = 0;
    data_in     = '0;
    data_stb_in = 1'b0;
    benchCs     = '0;
`ifdef SPDIF_TX_CHSTAT_EN
    benchCs[2]  = 1'b1;
    benchCs[25] = 1'b1;
    benchCs[33] = 1'b1;
`endif

    // Reset for 10 cycles, then release; current cycle is cell 0.
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");
    checkOutput("reset_line", 32'(spdif_out), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_underrun", 32'(underrun), 32'd0);
    checkOutput("reset_block_start", 32'(block_start), 32'd1);

    // Frame 0: no stimulus.
    applyStimulus(-1, '0, -1, '0);
    decodeFrame();
    checkOutput("f0_preA_B", 32'(preA), 32'(8'b11101000));
    checkOutput("f0_preB_W", 32'(preB), 32'(8'b11100100));
    checkOutput("f0_smpA", 32'(smpA), 32'h0);
    checkOutput("f0_smpB", 32'(smpB), 32'h0);
    checkOutput("f0_vA", 32'(vA), 32'd1);
    checkOutput("f0_vB", 32'(vB), 32'd1);
    checkOutput("f0_parA", 32'(parA), 32'd0);
    checkOutput("f0_bmc", 32'(bmcErr), 32'd0);
    checkOutput("f0_underrun_cnt", 32'(underCnt), 32'd1);
    checkOutput("f0_underrun_at", 32'(underAt), 32'd127);
    checkOutput("f0_done_cnt", 32'(doneCnt), 32'd0);
    checkOutput("f0_bs_other", 32'(bsOther), 32'd0);

    // Frame 1: strobe 1234_ABCD at cell 10.
    applyStimulus(10, 32'h1234_ABCD, -1, '0);
    decodeFrame();
    checkOutput("f1_preA_M", 32'(preA), 32'(8'b11100010));
    checkOutput("f1_vA", 32'(vA), 32'd1);
    checkOutput("f1_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("f1_done_at", 32'(doneAt), 32'd127);
    checkOutput("f1_underrun_cnt", 32'(underCnt), 32'd0);

    // Frame 2: carries 1234_ABCD, valid.
    applyStimulus(-1, '0, -1, '0);
    decodeFrame();
    checkOutput("f2_smpA", 32'(smpA), 32'h1234);
    checkOutput("f2_smpB", 32'(smpB), 32'hABCD);
    checkOutput("f2_vA", 32'(vA), 32'd0);
    checkOutput("f2_vB", 32'(vB), 32'd0);
    checkOutput("f2_uA", 32'(uA), 32'd0);
    checkOutput("f2_cA", 32'(cA), 32'(benchCs[2]));
    checkOutput("f2_parA", 32'(parA), 32'd0);
    checkOutput("f2_parB", 32'(parB), 32'd0);
    checkOutput("f2_bmc", 32'(bmcErr), 32'd0);
    checkOutput("f2_underrun_cnt", 32'(underCnt), 32'd1);

    // Frame 3: two strobes, newest wins, one done.
    applyStimulus(20, 32'h1111_1111, 50, 32'h2222_2222);
    decodeFrame();
    checkOutput("f3_smpA_kept", 32'(smpA), 32'h1234);
    checkOutput("f3_vA_underrun", 32'(vA), 32'd1);
    checkOutput("f3_done_cnt", 32'(doneCnt), 32'd1);

    // Frame 4: carries 2222_2222.
    applyStimulus(-1, '0, -1, '0);
    decodeFrame();
    checkOutput("f4_smpA", 32'(smpA), 32'h2222);
    checkOutput("f4_smpB", 32'(smpB), 32'h2222);
    checkOutput("f4_vA", 32'(vA), 32'd0);
    checkOutput("f4_done_cnt", 32'(doneCnt), 32'd0);

    // Frame 5: hold 0101_0202, then strobe 5555_AAAA on cell 127.
    applyStimulus(30, 32'h0101_0202, 127, 32'h5555_AAAA);
    decodeFrame();
    checkOutput("f5_smpB_kept", 32'(smpB), 32'h2222);
    checkOutput("f5_vB_underrun", 32'(vB), 32'd1);
    checkOutput("f5_done_cnt", 32'(doneCnt), 32'd1);

    // Frame 6: old held value; new value still pending.
    applyStimulus(-1, '0, -1, '0);
    decodeFrame();
    checkOutput("f6_smpA", 32'(smpA), 32'h0101);
    checkOutput("f6_smpB", 32'(smpB), 32'h0202);
    checkOutput("f6_vA", 32'(vA), 32'd0);
    checkOutput("f6_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("f6_underrun_cnt", 32'(underCnt), 32'd0);

    // Frame 7: the coinciding strobe's value.
    applyStimulus(-1, '0, -1, '0);
    decodeFrame();
    checkOutput("f7_smpA", 32'(smpA), 32'h5555);
    checkOutput("f7_smpB", 32'(smpB), 32'hAAAA);
    checkOutput("f7_vB", 32'(vB), 32'd0);
    checkOutput("f7_underrun_cnt", 32'(underCnt), 32'd1);

    // Frames 8..191 and frame 0 of the next block with a continuous feed.
    $display("[TB] continuous feed over one block");
    expData = 32'h5555_AAAA;
    expV    = 1'b1;
    for (int f = 8; f <= 192; f++) begin
      fr   = f % 192;
      feed = {16'(f) ^ 16'h5A5A, 16'(f * 7) + 16'h1000};
      if (f == 192) checkOutput("block_period", 32'(cycleCnt), 32'd24576);
      applyStimulus(5, feed, -1, '0);
      decodeFrame();
      checkOutput("blk_bs_start", 32'(bsAtStart), 32'(fr == 0));
      checkOutput("blk_bs_other", 32'(bsOther), 32'd0);
      checkOutput("blk_preA", 32'(preA),
                  (fr == 0) ? 32'(8'b11101000) : 32'(8'b11100010));
      checkOutput("blk_preB", 32'(preB), 32'(8'b11100100));
      checkOutput("blk_data", {smpA, smpB}, expData);
      checkOutput("blk_vA", 32'(vA), 32'(expV));
      checkOutput("blk_cA", 32'(cA), 32'(benchCs[fr]));
      checkOutput("blk_cB", 32'(cB), 32'(benchCs[fr]));
      checkOutput("blk_par", 32'({parA, parB}), 32'd0);
      checkOutput("blk_bmc", 32'(bmcErr), 32'd0);
      checkOutput("blk_done", 32'(doneCnt), 32'd1);
      expData = feed;
      expV    = 1'b0;
    end

    // Mid-frame reset at cell 40 with a sample held.
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      data_stb_in = (k == 10);
      if (k == 10) data_in = 32'hDEAD_BEEF;
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    data_stb_in = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    reset = 1'b0;
    checkOutput("mid_reset_no_done", 32'(dn), 32'd0);
    checkOutput("mid_reset_bs", 32'(block_start), 32'd1);
    checkOutput("mid_reset_line", 32'(spdif_out), 32'd0);
    applyStimulus(-1, '0, -1, '0);
    decodeFrame();
    checkOutput("mid_preA_B", 32'(preA), 32'(8'b11101000));
    checkOutput("mid_data", {smpA, smpB}, 32'h0);
    checkOutput("mid_vA", 32'(vA), 32'd1);
    checkOutput("mid_done_cnt", 32'(doneCnt), 32'd0);
    checkOutput("mid_underrun_cnt", 32'(underCnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
